// File: rtl/data_83_dist.sv
// data_83_dist: eight-channel data distributor.
//
// A write request (wr, held high until ack) captures indata and a destination.
// The destination is addr when auto=0, or the internal round-robin pointer
// when auto=1. The captured word is then loaded into the selected output
// channel, and the write is acknowledged. One wr assertion gives exactly one
// write.
//
// Write timeline, in cycles after the edge E0 that samples wr high in IDLE:
//   LOAD cycle : data held internally; no visible change yet
//   ACK cycle  : outN shows the new word, upd pulses, ack=1
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   indata[DW]   word to distribute
//   addr[3]      destination channel when auto=0 (0 -> out1 ... 7 -> out8)
//   wr           level write request
//   auto         1 = destination taken from ptr
//   clr          synchronous clear of channels, written mask and ptr
//   out1..out8   registered channel outputs
//   upd[8]       one-hot pulse marking the channel that just took new data
//   ack          one-cycle write acknowledge
//   full         every channel written since the last reset/clear
//   ptr[3]       auto-mode pointer
module data_83_dist #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] indata,
    input  logic [2:0]    addr,
    input  logic          wr,
    input  logic          auto,
    input  logic          clr,
    output logic [DW-1:0] out1,
    output logic [DW-1:0] out2,
    output logic [DW-1:0] out3,
    output logic [DW-1:0] out4,
    output logic [DW-1:0] out5,
    output logic [DW-1:0] out6,
    output logic [DW-1:0] out7,
    output logic [DW-1:0] out8,
    output logic [7:0]    upd,
    output logic          ack,
    output logic          full,
    output logic [2:0]    ptr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [2:0]      dest_q, dest_d;
    logic            used_ptr_q, used_ptr_d;
    logic [DW-1:0]   out_q [8];
    logic [DW-1:0]   out_d [8];
    logic [7:0]      mask_q, mask_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [7:0]      upd_q, upd_d;
    logic            ack_q, ack_d;
    logic            full_q, full_d;

    // Next-state, holding registers, channel writes and output pulses.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        dest_d     = dest_q;
        used_ptr_d = used_ptr_q;
        out_d      = out_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        upd_d      = 8'd0;
        ack_d      = 1'b0;

        if (clr) begin
            // Clear discards any captured write; no ack/upd are produced.
            state_d = IDLE;
            for (int i = 0; i < 8; i++) begin
                out_d[i] = '0;
            end
            mask_d = 8'd0;
            ptr_d  = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr) begin
                        data_d     = indata;
                        dest_d     = auto ? ptr_q : addr;
                        used_ptr_d = auto;
                        state_d    = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    out_d[dest_q]  = data_q;
                    upd_d          = 8'd1 << dest_q;
                    mask_d[dest_q] = 1'b1;
                    // Only a pointer-addressed write advances the pointer.
                    if (used_ptr_q) begin
                        ptr_d = ptr_q + 3'd1;
                    end else begin
                        ptr_d = ptr_q;
                    end
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
                ACK: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    // Hold here until wr drops so a long wr is one write.
                    if (wr) begin
                        state_d = WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        full_d = &mask_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            dest_q     <= 3'd0;
            used_ptr_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= '0;
            end
            mask_q <= 8'd0;
            ptr_q  <= 3'd0;
            upd_q  <= 8'd0;
            ack_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
            used_ptr_q <= used_ptr_d;
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= out_d[i];
            end
            mask_q <= mask_d;
            ptr_q  <= ptr_d;
            upd_q  <= upd_d;
            ack_q  <= ack_d;
            full_q <= full_d;
        end
    end

    assign out1 = out_q[0];
    assign out2 = out_q[1];
    assign out3 = out_q[2];
    assign out4 = out_q[3];
    assign out5 = out_q[4];
    assign out6 = out_q[5];
    assign out7 = out_q[6];
    assign out8 = out_q[7];
    assign upd  = upd_q;
    assign ack  = ack_q;
    assign full = full_q;
    assign ptr  = ptr_q;

endmodule

// File: doc/data_83_dist.md
DATA_83_DIST -- requirements
Module: data_83_dist

Interface
REQ-001 Parameter: DW, 4, data width of the input word and of each output channel.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: indata  input  DW  word to distribute.
REQ-005 Port: addr  input  3  destination channel (0 -> out1 ... 7 -> out8); used only when auto=0.
REQ-006 Port: wr  input  1  write request, level; held high until ack is seen.
REQ-007 Port: auto  input  1  1 = destination taken from the internal pointer instead of addr.
REQ-008 Port: clr  input  1  synchronous clear of all channels, the mask and the pointer.
REQ-009 Port: out1..out8  output  DW each  registered channel outputs.
REQ-010 Port: upd  output  8  one-cycle pulse; bit i set in the cycle channel i+1 takes new data.
REQ-011 Port: ack  output  1  one-cycle write acknowledge.
REQ-012 Port: full  output  1  high while all 8 channels have been written since the last reset or clear.
REQ-013 Port: ptr  output  3  current auto-mode pointer.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, ACK and WAIT.
REQ-015 IDLE: wr=1 and clr=0 -> LOAD, capturing indata and the destination (addr, or ptr if auto=1) into internal holding registers.
REQ-016 LOAD: the captured word is written to the captured channel, the matching upd bit pulses in the next cycle, the mask bit is set, and the FSM goes to ACK.
REQ-017 ACK: ack=1 for exactly this cycle, and the FSM goes to WAIT.
REQ-018 WAIT: the FSM stays while wr=1 and returns to IDLE when wr=0, so one wr assertion equals exactly one write.
REQ-019 Write latency: the channel output changes 2 cycles after the edge where wr is first sampled high in IDLE, and ack is high in that same cycle.
REQ-020 Changes to indata, addr or auto after capture SHALL NOT affect the write in progress.
REQ-021 Non-addressed channels SHALL hold their value.
REQ-022 Auto mode: ptr increments by 1 in LOAD when the write used ptr, wrapping 7 -> 0; ptr does not change when auto=0.
REQ-023 full = AND of the 8-bit written mask; rewriting a channel leaves the mask unchanged.
REQ-024 clr=1 in any state: all outputs, the mask and ptr go to 0, the FSM goes to IDLE, and any captured write is discarded with no ack or upd.
REQ-025 clr and wr high together in IDLE: clr wins, and wr SHALL be re-sampled in the following cycle (a still-high wr then starts a write).
REQ-026 upd and ack SHALL never be high outside the cycles defined above; upd is one-hot or zero.

Reset
REQ-027 rst=1 SHALL set out1..out8=0, upd=0, ack=0, full=0, ptr=0, mask=0 and FSM=IDLE at the next edge.
REQ-028 rst has priority over clr and wr; rst mid-write aborts the write with no ack and no output change.

Verification
REQ-029 Reset, then wr=1 with addr=5 and indata=0xA -> out6=0xA and upd=8'b0010_0000 and ack=1 two cycles later; all other outputs 0.
REQ-030 Hold wr=1 for 6 cycles with addr=2 and indata=0x3 -> exactly one ack and one upd pulse; out3=0x3.
REQ-031 auto=1, eight writes of 0x1..0x8 -> out1..out8=0x1..0x8, full=1 after the 8th ack, ptr wraps back to 0.
REQ-032 auto=1 with ptr=7, one write -> out8 updated and ptr=0.
REQ-033 clr asserted in the LOAD cycle -> no ack, outputs, mask and ptr all 0, FSM returns to IDLE.
REQ-034 rst asserted in the ACK cycle -> ack deasserts next cycle, all state returns to the reset values, and a following write works normally.
